// File: rtl/arbiter_types.sv
// Shared types for the cache-to-memory arbiter: FSM states, grant side,
// and the line-offset width derivation used to line-align addresses.
package arbiter_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // Number of byte-offset bits inside one cache line.
  function automatic int line_offset_bits(input int line_width);
    return $clog2(line_width / 8);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter placing I-cache and D-cache line traffic onto a single
// physical-memory port. One transaction in flight; request fields are latched
// at grant so the memory side sees stable values; every output is registered.
module mem_arbiter
  import arbiter_types::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam int OFFSET_BITS = line_offset_bits(LINE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

  state_t                state_reg, state_next;
  grant_t                last_grant_reg, last_grant_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [LINE_WIDTH-1:0] wdata_reg, wdata_next;
  logic                  pmem_read_reg, pmem_read_next;
  logic                  pmem_write_reg, pmem_write_next;
  logic [LINE_WIDTH-1:0] i_rdata_reg, i_rdata_next;
  logic [LINE_WIDTH-1:0] d_rdata_reg, d_rdata_next;
  logic                  i_resp_reg, i_resp_next;
  logic                  d_resp_reg, d_resp_next;
  logic                  req_i, req_d;

  // Arbitration, payload capture and completion handling.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    pmem_read_next  = pmem_read_reg;
    pmem_write_next = pmem_write_reg;
    i_rdata_next    = i_rdata_reg;
    d_rdata_next    = d_rdata_reg;
    i_resp_next     = 1'b0;
    d_resp_next     = 1'b0;
    req_i           = i_read;
    req_d           = d_read | d_write;

    case (state_reg)
      IDLE: begin
        // On a tie, the side that did not win last time is served.
        if (req_i && (!req_d || last_grant_reg == GRANT_D)) begin
          state_next      = BUSY_I;
          last_grant_next = GRANT_I;
          addr_next       = i_address & LINE_MASK;
          pmem_read_next  = 1'b1;
          pmem_write_next = 1'b0;
        end else if (req_d) begin
          state_next      = BUSY_D;
          last_grant_next = GRANT_D;
          addr_next       = d_address & LINE_MASK;
          // Read and write together is illegal; it is served as a writeback.
          pmem_read_next  = ~d_write;
          pmem_write_next = d_write;
          if (d_write) begin
            wdata_next = d_wdata;
          end
        end
      end
      BUSY_I: begin
        if (pmem_resp) begin
          state_next      = DONE;
          i_resp_next     = 1'b1;
          i_rdata_next    = pmem_rdata;
          pmem_read_next  = 1'b0;
          pmem_write_next = 1'b0;
        end
      end
      BUSY_D: begin
        if (pmem_resp) begin
          state_next      = DONE;
          d_resp_next     = 1'b1;
          // A writeback returns no line, so d_rdata keeps its old value.
          if (!pmem_write_reg) begin
            d_rdata_next = pmem_rdata;
          end
          pmem_read_next  = 1'b0;
          pmem_write_next = 1'b0;
        end
      end
      DONE: begin
        // One dead cycle so the requester can drop its request before rearbitration.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and payload registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_D;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      pmem_read_reg  <= 1'b0;
      pmem_write_reg <= 1'b0;
      i_rdata_reg    <= '0;
      d_rdata_reg    <= '0;
      i_resp_reg     <= 1'b0;
      d_resp_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      pmem_read_reg  <= pmem_read_next;
      pmem_write_reg <= pmem_write_next;
      i_rdata_reg    <= i_rdata_next;
      d_rdata_reg    <= d_rdata_next;
      i_resp_reg     <= i_resp_next;
      d_resp_reg     <= d_resp_next;
    end
  end

  assign i_rdata      = i_rdata_reg;
  assign i_resp       = i_resp_reg;
  assign d_rdata      = d_rdata_reg;
  assign d_resp       = d_resp_reg;
  assign pmem_read    = pmem_read_reg;
  assign pmem_write   = pmem_write_reg;
  assign pmem_address = addr_reg;
  assign pmem_wdata   = wdata_reg;

  // Simulation-only flags for illegal requester and memory behaviour.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(state_reg == IDLE && d_read && d_write))
        else $warning("mem_arbiter: d_read and d_write both high, served as writeback");
      assert (!pmem_resp || state_reg == BUSY_I || state_reg == BUSY_D)
        else $warning("mem_arbiter: pmem_resp outside a transaction is ignored");
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected responses into a
// queue, a monitor pops and compares on every i_resp/d_resp.
module tb_mem_arbiter;

  localparam int LW  = 256;
  localparam int AW  = 32;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_d;
    logic [LW-1:0] rdata;
  } exp_t;

  exp_t          exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            i_resp_cnt = 0;
  int            d_resp_cnt = 0;
  int            txn_cnt = 0;
  logic [LW-1:0] last_i = '0;
  logic [LW-1:0] last_d = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [LW-1:0] wr_data = '0;
  bit            mem_auto = 1'b1;
  bit            manual_resp = 1'b0;

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    return {8{a ^ 32'h5AC3_0F96}};
  endfunction

  function automatic void chk(input string name, input logic [LW-1:0] act,
                              input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endfunction

  // Memory model: answers a strobe after LAT cycles; manual mode for reset test.
  initial begin
    int cnt;
    cnt        = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_auto) begin
        pmem_resp = manual_resp;
        cnt       = 0;
      end else if ((pmem_read || pmem_write) && !pmem_resp) begin
        cnt++;
        if (cnt == LAT + 1) begin
          pmem_resp  = 1'b1;
          pmem_rdata = line_of(pmem_address);
          if (pmem_write) begin
            wr_addr = pmem_address;
            wr_data = pmem_wdata;
          end
          txn_cnt++;
          cnt = 0;
        end
      end else begin
        pmem_resp = 1'b0;
        cnt       = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (pmem_read || pmem_write)
        chk("pmem_strobe_exclusive", {255'd0, pmem_read && pmem_write}, '0);
      if (i_resp || d_resp) begin
        chk("resp_exclusive", {255'd0, i_resp && d_resp}, '0);
        if (i_resp) i_resp_cnt++;
        if (d_resp) d_resp_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", {254'd0, d_resp, i_resp}, '0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_side", {255'd0, d_resp}, {255'd0, e.is_d});
          chk("resp_rdata", d_resp ? d_rdata : i_rdata, e.rdata);
          $display("resp %s rdata=%h", d_resp ? "D" : "I", d_resp ? d_rdata : i_rdata);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input bit side_d, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(side_d ? d_resp : i_resp) && cyc < 60);
    if (!(side_d ? d_resp : i_resp)) chk("resp_timeout", 256'd0, 256'd1);
  endtask

  task automatic issue_i(input logic [AW-1:0] a);
    exp_t e;
    e.is_d = 1'b0;
    e.rdata = line_of(a & 32'hFFFF_FFE0);
    last_i = e.rdata;
    exp_q.push_back(e);
    i_address = a;
    i_read    = 1'b1;
  endtask

  task automatic issue_d(input logic [AW-1:0] a, input bit wr, input bit rd,
                         input logic [LW-1:0] wd);
    exp_t e;
    e.is_d = 1'b1;
    if (rd && !wr) last_d = line_of(a & 32'hFFFF_FFE0);
    e.rdata = last_d;
    exp_q.push_back(e);
    d_address = a;
    d_wdata   = wd;
    d_read    = rd;
    d_write   = wr;
  endtask

  initial begin
    int cyc;
    int i0, d0, t0, target, budget;
    bit read_seen, unstable;

    rst = 1'b0;
    i_read = 0; i_address = '0; d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_pmem_read", {255'd0, pmem_read}, '0);
    chk("rst_pmem_write", {255'd0, pmem_write}, '0);
    chk("rst_pmem_address", {224'd0, pmem_address}, '0);
    chk("rst_pmem_wdata", pmem_wdata, '0);
    chk("rst_i_rdata", i_rdata, '0);
    chk("rst_d_rdata", d_rdata, '0);
    chk("rst_i_resp", {255'd0, i_resp}, '0);
    chk("rst_d_resp", {255'd0, d_resp}, '0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Both requesters rise together from reset and stay high: I, D, I, D...
    i0 = i_resp_cnt; d0 = d_resp_cnt;
    for (int k = 0; k < 4; k++) begin
      issue_i(32'h0000_1000);
      issue_d(32'h0000_2000, 1'b0, 1'b1, '0);
    end
    tick();
    chk("tie_first_grant_is_i", {255'd0, pmem_read}, 256'd1);
    chk("tie_first_addr", {224'd0, pmem_address}, {224'd0, 32'h0000_1000});
    target = i0 + d0 + 8;
    budget = 0;
    while ((i_resp_cnt + d_resp_cnt) < target && budget < 200) begin
      @(posedge clk);
      #2;
      budget++;
    end
    i_read = 0; d_read = 0;
    if (budget >= 200) chk("alt_timeout", 256'd0, 256'd1);
    chk("alt_i_count", 256'(i_resp_cnt - i0), 256'd4);
    chk("alt_d_count", 256'(d_resp_cnt - d0), 256'd4);
    repeat (10) tick();
    chk("alt_quiet_after_drop", {254'd0, pmem_read, pmem_write}, '0);

    // I-only read, latency 4: strobe one cycle after request, resp at 6.
    issue_i(32'h0000_1234);
    tick();
    chk("i_strobe_latency", {254'd0, pmem_read, pmem_write}, {254'd0, 2'b10});
    chk("i_line_address", {224'd0, pmem_address}, {224'd0, 32'h0000_1220});
    wait_resp(1'b0, cyc);
    i_read = 0;
    chk("i_resp_latency", 256'(cyc + 1), 256'd6);
    tick();
    chk("i_resp_one_cycle", {255'd0, i_resp}, '0);

    // D writeback with A5 pattern.
    issue_d(32'h8000_00E0, 1'b1, 1'b0, {32{8'hA5}});
    tick();
    chk("d_wr_strobe", {254'd0, pmem_read, pmem_write}, {254'd0, 2'b01});
    chk("d_wr_address", {224'd0, pmem_address}, {224'd0, 32'h8000_00E0});
    chk("d_wr_wdata", pmem_wdata, {32{8'hA5}});
    read_seen = 0; unstable = 0; cyc = 1;
    while (!d_resp && cyc < 60) begin
      tick();
      cyc++;
      if (pmem_read) read_seen = 1;
      if (pmem_write && (pmem_address !== 32'h8000_00E0 || pmem_wdata !== {32{8'hA5}}))
        unstable = 1;
    end
    d_write = 0;
    if (!d_resp) chk("d_wr_timeout", 256'd0, 256'd1);
    chk("d_wr_no_read", {255'd0, read_seen}, '0);
    chk("d_wr_stable", {255'd0, unstable}, '0);
    chk("d_wr_mem_addr", {224'd0, wr_addr}, {224'd0, 32'h8000_00E0});
    chk("d_wr_mem_data", wr_data, {32{8'hA5}});

    // d_read held through d_resp, dropped in DONE: exactly one memory transaction.
    t0 = txn_cnt;
    issue_d(32'h0000_4040, 1'b0, 1'b1, '0);
    wait_resp(1'b1, cyc);
    d_read = 0;
    repeat (12) tick();
    chk("held_read_single_txn", 256'(txn_cnt - t0), 256'd1);
    chk("held_read_idle", {254'd0, pmem_read, pmem_write}, '0);

    // Illegal d_read+d_write is served as a writeback.
    issue_d(32'h0000_0100, 1'b1, 1'b1, {8{32'hDEAD_BEEF}});
    tick();
    chk("rw_both_is_write", {254'd0, pmem_read, pmem_write}, {254'd0, 2'b01});
    wait_resp(1'b1, cyc);
    d_read = 0; d_write = 0;
    chk("rw_both_mem_data", wr_data, {8{32'hDEAD_BEEF}});
    tick();

    // Reset two cycles into BUSY_I, late pmem_resp after release.
    mem_auto = 0;
    i_address = 32'h0000_5000;
    i_read = 1;
    tick();
    tick();
    chk("busy_before_reset", {255'd0, pmem_read}, 256'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_pmem_read", {255'd0, pmem_read}, '0);
    chk("mid_rst_address", {224'd0, pmem_address}, '0);
    chk("mid_rst_wdata", pmem_wdata, '0);
    chk("mid_rst_i_rdata", i_rdata, '0);
    chk("mid_rst_d_rdata", d_rdata, '0);
    i_read = 0;
    last_i = '0; last_d = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    i0 = i_resp_cnt;
    @(negedge clk);
    manual_resp = 1;
    @(negedge clk);
    manual_resp = 0;
    repeat (6) tick();
    chk("late_resp_ignored", 256'(i_resp_cnt - i0), '0);
    mem_auto = 1;
    issue_i(32'h0000_3000);
    tick();
    chk("post_rst_strobe", {255'd0, pmem_read}, 256'd1);
    wait_resp(1'b0, cyc);
    i_read = 0;
    chk("post_rst_latency", 256'(cyc + 1), 256'd6);
    repeat (4) tick();
    chk("scoreboard_drained", 256'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
